hazard_scoreboard: RTL and testbench

//  Parametrised hazard/stall controller for the 5-stage pipeline. Decodes FD and DX instruction words.

---
 rtl/hazard_scoreboard.sv | 169 ++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard/stall controller for the 5-stage pipeline.
// Raises the FD freeze / DX bubble for load-use, multdiv structural and multdiv data hazards,
// sequences one in-flight multdiv op, arbitrates its writeback slot against MW, and keeps a
// saturating count of stalled cycles.
module hazard_scoreboard #(
    parameter int unsigned MULT_LATENCY = 32,
    parameter int unsigned DIV_LATENCY  = 32,
    parameter int unsigned NONBLOCKING  = 1,
    parameter int unsigned STALL_CNT_W  = 16
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic [31:0]            fd_ir_i,
    input  logic [31:0]            dx_ir_i,
    input  logic                   mw_writes_i,
    input  logic                   md_ready_i,
    input  logic                   stat_clear_i,
    output logic                   stall_fd_o,
    output logic                   bubble_dx_o,
    output logic                   md_start_o,
    output logic                   md_busy_o,
    output logic                   md_wb_en_o,
    output logic [4:0]             md_wb_rd_o,
    output logic [STALL_CNT_W-1:0] stall_count_o
);

    localparam int unsigned MaxLat = (MULT_LATENCY > DIV_LATENCY) ? MULT_LATENCY : DIV_LATENCY;
    localparam int unsigned CntW   = ($clog2(MaxLat + 1) > 6) ? $clog2(MaxLat + 1) : 6;

    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] MultLat = CntW'(MULT_LATENCY);
    localparam logic [CntW-1:0] DivLat  = CntW'(DIV_LATENCY);

    localparam logic [4:0] OpR     = 5'b00000;
    localparam logic [4:0] OpJal   = 5'b00011;
    localparam logic [4:0] OpAddi  = 5'b00101;
    localparam logic [4:0] OpSw    = 5'b00111;
    localparam logic [4:0] OpLw    = 5'b01000;
    localparam logic [4:0] AluMult = 5'b00110;
    localparam logic [4:0] AluDiv  = 5'b00111;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StWb
    } state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [4:0]             pend_rd_q, pend_rd_d;
    logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

    // Instruction field decode
    logic [4:0] fd_op, fd_rd, fd_rs, fd_rt, fd_alu;
    logic [4:0] dx_op, dx_rd, dx_alu;
    logic [4:0] fd_dest;
    logic       fd_is_md, dx_is_md, dx_is_lw, fd_is_sw, fd_writes;

    assign fd_op  = fd_ir_i[31:27];
    assign fd_rd  = fd_ir_i[26:22];
    assign fd_rs  = fd_ir_i[21:17];
    assign fd_rt  = fd_ir_i[16:12];
    assign fd_alu = fd_ir_i[6:2];
    assign dx_op  = dx_ir_i[31:27];
    assign dx_rd  = dx_ir_i[26:22];
    assign dx_alu = dx_ir_i[6:2];

    assign fd_is_md  = (fd_op == OpR) && ((fd_alu == AluMult) || (fd_alu == AluDiv));
    assign dx_is_md  = (dx_op == OpR) && ((dx_alu == AluMult) || (dx_alu == AluDiv));
    assign dx_is_lw  = (dx_op == OpLw);
    assign fd_is_sw  = (fd_op == OpSw);
    assign fd_writes = (fd_op == OpR) || (fd_op == OpAddi) || (fd_op == OpLw) || (fd_op == OpJal);
    assign fd_dest   = (fd_op == OpJal) ? 5'd31 : fd_rd;

    // Fields the scoreboard never looks at
    logic unused_ir;
    assign unused_ir = ^{fd_ir_i[11:7], fd_ir_i[1:0], dx_ir_i[21:7], dx_ir_i[1:0]};

    // FD reads or overwrites the pending multdiv destination (r0 never counts)
    logic dep_pend, dep_dx;
    assign dep_pend = (pend_rd_q != 5'd0) &&
                      ((fd_rs == pend_rd_q) || (fd_rt == pend_rd_q) ||
                       (fd_writes && (fd_dest == pend_rd_q)));
    // Same test against a multdiv that is launching from DX this cycle
    assign dep_dx   = (dx_rd != 5'd0) &&
                      ((fd_rs == dx_rd) || (fd_rt == dx_rd) ||
                       (fd_writes && (fd_dest == dx_rd)));

    // Stall decision: OR of load-use, structural and multdiv data hazards
    always_comb begin
        logic load_use, structural, md_data;
        load_use   = dx_is_lw && (dx_rd != 5'd0) &&
                     ((fd_rs == dx_rd) || ((fd_rt == dx_rd) && !fd_is_sw));
        structural = fd_is_md && ((state_q != StIdle) || dx_is_md);
        if (NONBLOCKING != 0) begin
            md_data = ((state_q != StIdle) && dep_pend) || (dx_is_md && dep_dx);
        end else begin
            md_data = (state_q != StIdle) || dx_is_md;
        end
        stall_fd_o = load_use || structural || md_data;
    end

    assign bubble_dx_o   = stall_fd_o;
    assign md_busy_o     = (state_q != StIdle);
    assign md_wb_rd_o    = pend_rd_q;
    assign stall_count_o = stall_count_q;

    // Multdiv sequencer next state: launch, count down (or early ready), then win the WB slot
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_rd_d  = pend_rd_q;
        md_start_o = 1'b0;
        md_wb_en_o = 1'b0;
        case (state_q)
            StIdle: begin
                if (dx_is_md) begin
                    md_start_o = 1'b1;
                    pend_rd_d  = dx_rd;
                    cnt_d      = (dx_alu == AluMult) ? MultLat : DivLat;
                    state_d    = StBusy;
                end
            end
            StBusy: begin
                cnt_d = cnt_q - CntOne;
                if ((cnt_q == CntOne) || md_ready_i) begin
                    state_d = StWb;
                end
            end
            StWb: begin
                // MW owns the regfile write port; hold the result until it is free
                md_wb_en_o = ~mw_writes_i;
                if (!mw_writes_i) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Stall-cycle counter next state: clear wins, otherwise saturating increment
    always_comb begin
        stall_count_d = stall_count_q;
        if (stat_clear_i) begin
            stall_count_d = '0;
        end else if (stall_fd_o && !(&stall_count_q)) begin
            stall_count_d = stall_count_q + STALL_CNT_W'(1);
        end
    end

    // State registers; reset abandons any in-flight multdiv
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            pend_rd_q     <= 5'd0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pend_rd_q     <= pend_rd_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (non-blocking and blocking flavours) share one
// directed stimulus stream; a timeline model predicts every output each cycle, and literal
// expectations pin the interesting cycles.
module tb_hazard_scoreboard;

    localparam int unsigned AMul = 4;
    localparam int unsigned ADiv = 12;
    localparam int unsigned BMul = 3;
    localparam int unsigned BDiv = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fd_ir, dx_ir;
    logic        mw_writes, md_ready, stat_clear;

    logic        a_stall, a_bub, a_start, a_busy, a_wben;
    logic [4:0]  a_wbrd;
    logic [15:0] a_cnt;
    logic        b_stall, b_bub, b_start, b_busy, b_wben;
    logic [4:0]  b_wbrd;
    logic [3:0]  b_cnt;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .MULT_LATENCY(AMul), .DIV_LATENCY(ADiv), .NONBLOCKING(1), .STALL_CNT_W(16)
    ) u_a (
        .clock_i(clk), .reset_i(rst), .fd_ir_i(fd_ir), .dx_ir_i(dx_ir),
        .mw_writes_i(mw_writes), .md_ready_i(md_ready), .stat_clear_i(stat_clear),
        .stall_fd_o(a_stall), .bubble_dx_o(a_bub), .md_start_o(a_start), .md_busy_o(a_busy),
        .md_wb_en_o(a_wben), .md_wb_rd_o(a_wbrd), .stall_count_o(a_cnt)
    );

    hazard_scoreboard #(
        .MULT_LATENCY(BMul), .DIV_LATENCY(BDiv), .NONBLOCKING(0), .STALL_CNT_W(4)
    ) u_b (
        .clock_i(clk), .reset_i(rst), .fd_ir_i(fd_ir), .dx_ir_i(dx_ir),
        .mw_writes_i(mw_writes), .md_ready_i(md_ready), .stat_clear_i(stat_clear),
        .stall_fd_o(b_stall), .bubble_dx_o(b_bub), .md_start_o(b_start), .md_busy_o(b_busy),
        .md_wb_en_o(b_wben), .md_wb_rd_o(b_wbrd), .stall_count_o(b_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each instance: is a multdiv in flight, first cycle its result may be written, its dest.
    bit         m_fly[2];
    int         m_wb_from[2];
    logic [4:0] m_pend[2];
    int         m_cnt[2];
    int         cyc = 0;

    function automatic bit is_md(input logic [31:0] ir);
        return (ir[31:27] == 5'b00000) && ((ir[6:2] == 5'b00110) || (ir[6:2] == 5'b00111));
    endfunction

    function automatic int lat(input int k, input logic [31:0] ir);
        if (ir[6:2] == 5'b00110) return (k == 0) ? AMul : BMul;
        return (k == 0) ? ADiv : BDiv;
    endfunction

    function automatic int cnt_max(input int k);
        return (k == 0) ? 65535 : 15;
    endfunction

    // Does instruction ir read register r or write it?
    function automatic bit touches(input logic [31:0] ir, input logic [4:0] r);
        logic [4:0] op, dest;
        bit wr;
        op   = ir[31:27];
        wr   = (op == 5'b00000) || (op == 5'b00101) || (op == 5'b01000) || (op == 5'b00011);
        dest = (op == 5'b00011) ? 5'd31 : ir[26:22];
        return (r != 5'd0) && ((ir[21:17] == r) || (ir[16:12] == r) || (wr && dest == r));
    endfunction

    function automatic bit exp_stall(input int k, input logic [31:0] fd, input logic [31:0] dx);
        logic [4:0] drd;
        bit lu, st, dh;
        drd = dx[26:22];
        lu  = (dx[31:27] == 5'b01000) && (drd != 5'd0) &&
              ((fd[21:17] == drd) || ((fd[16:12] == drd) && (fd[31:27] != 5'b00111)));
        st  = is_md(fd) && (m_fly[k] || is_md(dx));
        if (k == 0) dh = (m_fly[k] && touches(fd, m_pend[k])) || (is_md(dx) && touches(fd, drd));
        else        dh = m_fly[k] || is_md(dx);
        return lu || st || dh;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_fly[k]  = 1'b0;
                m_pend[k] = 5'd0;
                m_cnt[k]  = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (stat_clear) m_cnt[k] = 0;
                else if (exp_stall(k, fd_ir, dx_ir) && m_cnt[k] < cnt_max(k)) m_cnt[k]++;
                if (!m_fly[k]) begin
                    if (is_md(dx_ir)) begin
                        m_fly[k]     = 1'b1;
                        m_pend[k]    = dx_ir[26:22];
                        m_wb_from[k] = cyc + lat(k, dx_ir) + 1;
                    end
                end else if (cyc < m_wb_from[k]) begin
                    if (md_ready) m_wb_from[k] = cyc + 1;
                end else if (!mw_writes) begin
                    m_fly[k] = 1'b0;
                end
            end
            cyc++;
        end
    end

    // Per-cycle comparison against the model, mid-cycle
    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                logic        st, bu, sa, bz, we;
                logic [4:0]  rd;
                logic [31:0] ct;
                string       p;
                p  = (k == 0) ? "A" : "B";
                st = (k == 0) ? a_stall : b_stall;
                bu = (k == 0) ? a_bub : b_bub;
                sa = (k == 0) ? a_start : b_start;
                bz = (k == 0) ? a_busy : b_busy;
                we = (k == 0) ? a_wben : b_wben;
                rd = (k == 0) ? a_wbrd : b_wbrd;
                ct = (k == 0) ? 32'(a_cnt) : 32'(b_cnt);
                chk({p, ".stall_fd"}, st, exp_stall(k, fd_ir, dx_ir));
                chk({p, ".bubble_dx"}, bu, exp_stall(k, fd_ir, dx_ir));
                chk({p, ".md_start"}, sa, !m_fly[k] && is_md(dx_ir));
                chk({p, ".md_busy"}, bz, m_fly[k]);
                chk({p, ".md_wb_en"}, we, m_fly[k] && (cyc >= m_wb_from[k]) && !mw_writes);
                chk({p, ".md_wb_rd"}, rd, m_pend[k]);
                chk({p, ".stall_count"}, ct, m_cnt[k]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] alu);
        return {5'b00000, rd, rs, rt, 5'b00000, alu, 2'b00};
    endfunction

    function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [16:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic step(input logic [31:0] fd, input logic [31:0] dx,
                        input logic mw, input logic rdy, input logic clr);
        @(posedge clk);
        #1;
        fd_ir      = fd;
        dx_ir      = dx;
        mw_writes  = mw;
        md_ready   = rdy;
        stat_clear = clr;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] lw5, lw0, add652, add602, add625, sw_rt5, add812, add912, add731;
        logic [31:0] mul3, mul0, mul4, div10, addi3, add500, add11_10;
        lw5     = itype(5'b01000, 5'd5, 5'd1, 17'd0);
        lw0     = itype(5'b01000, 5'd0, 5'd1, 17'd0);
        add652  = rtype(5'd6, 5'd5, 5'd2, 5'd0);
        add602  = rtype(5'd6, 5'd0, 5'd2, 5'd0);
        add625  = rtype(5'd6, 5'd2, 5'd5, 5'd0);
        sw_rt5  = itype(5'b00111, 5'd1, 5'd2, {5'd5, 12'd0});
        add812  = rtype(5'd8, 5'd1, 5'd2, 5'd0);
        add912  = rtype(5'd9, 5'd1, 5'd2, 5'd0);
        add731  = rtype(5'd7, 5'd3, 5'd1, 5'd0);
        mul3    = rtype(5'd3, 5'd1, 5'd2, 5'b00110);
        mul0    = rtype(5'd0, 5'd1, 5'd2, 5'b00110);
        mul4    = rtype(5'd4, 5'd1, 5'd2, 5'b00110);
        div10   = rtype(5'd10, 5'd1, 5'd2, 5'b00111);
        addi3   = itype(5'b00101, 5'd3, 5'd1, 17'd0);
        add500  = rtype(5'd5, 5'd0, 5'd0, 5'd0);
        add11_10 = rtype(5'd11, 5'd10, 5'd1, 5'd0);

        rst = 1'b1;
        fd_ir = '0; dx_ir = '0; mw_writes = 1'b0; md_ready = 1'b0; stat_clear = 1'b0;
        @(posedge clk);
        #1 chk_on = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        step(0, 0, 0, 0, 0); mid();
        chk("rst.stall_fd", a_stall, 0);
        chk("rst.md_busy", a_busy, 0);
        chk("rst.md_wb_en", a_wben, 0);
        chk("rst.md_wb_rd", a_wbrd, 0);
        chk("rst.stall_count", a_cnt, 0);

        // Load-use
        step(add652, lw5, 0, 0, 0); mid();
        chk("lu.rs", a_stall, 1);
        chk("lu.bubble", a_bub, 1);
        step(add652, 0, 0, 0, 0); mid();
        chk("lu.released", a_stall, 0);
        step(add602, lw0, 0, 0, 0); mid();
        chk("lu.r0", a_stall, 0);
        step(sw_rt5, lw5, 0, 0, 0); mid();
        chk("lu.sw_rt", a_stall, 0);
        step(add625, lw5, 0, 0, 0); mid();
        chk("lu.rt", a_stall, 1);

        // Non-blocking mult r3, latency 4
        step(add812, mul3, 0, 0, 0); mid();
        chk("mul.start", a_start, 1);
        chk("mul.indep0", a_stall, 0);
        chk("mul.blocking_dx", b_stall, 1);
        chk("cnt.after_lu", a_cnt, 2);
        step(add912, add812, 0, 0, 0); mid();
        chk("mul.busy1", a_busy, 1);
        chk("mul.indep1", a_stall, 0);
        chk("mul.blocking_busy", b_stall, 1);
        step(add731, add912, 0, 0, 0); mid();
        chk("mul.raw2", a_stall, 1);
        step(add731, 0, 0, 0, 0);
        step(add731, 0, 0, 0, 0); mid();
        chk("mul.no_wb4", a_wben, 0);
        step(add731, 0, 0, 0, 0); mid();
        chk("mul.wb5", a_wben, 1);
        chk("mul.wb_rd", a_wbrd, 3);
        chk("mul.raw5", a_stall, 1);
        step(add731, 0, 0, 0, 0); mid();
        chk("mul.release6", a_stall, 0);
        chk("mul.idle6", a_busy, 0);

        // WAW against pending mult r3
        step(0, mul3, 0, 0, 0);
        step(addi3, 0, 0, 0, 0); mid();
        chk("waw.addi", a_stall, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);

        // mult r0: no data hazard, still writes back
        step(0, mul0, 0, 0, 0);
        step(add500, 0, 0, 0, 0); mid();
        chk("r0.no_haz", a_stall, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0); mid();
        chk("r0.wb_en", a_wben, 1);
        chk("r0.wb_rd", a_wbrd, 0);
        step(0, 0, 0, 0, 0);

        // Structural: FD div behind DX mult, then behind the busy unit
        step(div10, mul4, 0, 0, 0); mid();
        chk("st.dx_md", a_stall, 1);
        chk("st.start", a_start, 1);
        for (int i = 0; i < 4; i++) step(div10, 0, 0, 0, 0);
        step(div10, 0, 0, 0, 0); mid();
        chk("st.wb", a_stall, 1);
        step(div10, 0, 0, 0, 0); mid();
        chk("st.idle", a_stall, 0);

        // Early ready, then MW holds the WB slot for 3 cycles
        step(0, div10, 0, 0, 0); mid();
        chk("div.start", a_start, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0); mid();
        chk("div.wb_blocked", a_wben, 0);
        chk("div.wb_busy", a_busy, 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0); mid();
        chk("div.wb_en", a_wben, 1);
        chk("div.wb_rd", a_wbrd, 10);
        step(0, 0, 0, 0, 0); mid();
        chk("div.done_busy", a_busy, 0);
        chk("div.done_wb", a_wben, 0);

        // Stall counter: clear, saturation on the 4-bit instance, clear beats increment
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0); mid();
        chk("cnt.clr_a", a_cnt, 0);
        chk("cnt.clr_b", b_cnt, 0);
        for (int i = 0; i < 20; i++) step(add652, lw5, 0, 0, 0);
        step(add652, lw5, 0, 0, 1); mid();
        chk("cnt.sat_b", b_cnt, 15);
        chk("cnt.a20", a_cnt, 20);
        step(0, 0, 0, 0, 0); mid();
        chk("cnt.clr_prio_a", a_cnt, 0);
        chk("cnt.clr_prio_b", b_cnt, 0);

        // Reset mid-BUSY with cnt=10
        step(0, div10, 0, 0, 0);
        step(add11_10, 0, 0, 0, 0); mid();
        chk("rb.raw", a_stall, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        #1;
        chk("rb.pre_busy", a_busy, 1);
        chk("rb.pre_cnt", a_cnt, 1);
        rst = 1'b1;
        #1;
        chk("rb.busy", a_busy, 0);
        chk("rb.cnt", a_cnt, 0);
        chk("rb.wb_rd", a_wbrd, 0);
        chk("rb.busy_b", b_busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, 0, 0); mid();
            chk("rb.no_wb", a_wben, 0);
        end

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
